// File: rtl/vlc_manchester_tx.sv
// Manchester-coded OOK transmitter for the VLC link: one byte per frame,
// framed as alternating preamble, 8 data bits MSB-first, even parity, idle gap.
module vlc_manchester_tx #(
    parameter int unsigned HALF_BIT_DIV  = 5,
    parameter int unsigned PREAMBLE_BITS = 8,
    parameter int unsigned GAP_BITS      = 2,
    parameter logic        IDLE_LEVEL    = 1'b0
) (
    input  logic       aclk,
    input  logic       resetn,
    input  logic       tx_en,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       led_out,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned HW    = (HALF_BIT_DIV > 1) ? $clog2(HALF_BIT_DIV) : 1;
    localparam int unsigned BMAX0 = (PREAMBLE_BITS > 8) ? PREAMBLE_BITS : 8;
    localparam int unsigned BMAX  = (BMAX0 > 2 * GAP_BITS) ? BMAX0 : 2 * GAP_BITS;
    localparam int unsigned BW    = $clog2(BMAX + 1);

    localparam logic [HW-1:0] HLAST     = HW'(HALF_BIT_DIV - 1);
    localparam logic [BW-1:0] PRE_LAST  = BW'(PREAMBLE_BITS - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(7);
    localparam logic [BW-1:0] GAP_LAST  = BW'(2 * GAP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_PARITY,
        ST_GAP
    } state_t;

    state_t        state;
    logic [HW-1:0] hcnt;
    logic [BW-1:0] bcnt;
    logic          half;
    logic [7:0]    shreg;
    logic          par;
    logic          cur_bit;

    // Ready only when idle, enabled and out of reset
    assign s_ready = (state == ST_IDLE) & tx_en & resetn;

    // Logical value of the bit currently on the line
    always_comb begin
        cur_bit = 1'b0;
        case (state)
            ST_PREAMBLE: cur_bit = ~bcnt[0];
            ST_DATA:     cur_bit = shreg[7];
            ST_PARITY:   cur_bit = par;
            default:     cur_bit = 1'b0;
        endcase
    end

    // Frame sequencer; led_out only updates on half-bit boundaries (first half = ~bit)
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            hcnt       <= '0;
            bcnt       <= '0;
            half       <= 1'b0;
            shreg      <= '0;
            par        <= 1'b0;
            led_out    <= IDLE_LEVEL;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state == ST_IDLE) begin
                if (s_valid && s_ready) begin
                    shreg   <= s_data;
                    par     <= ^s_data;
                    state   <= ST_PREAMBLE;
                    hcnt    <= '0;
                    bcnt    <= '0;
                    half    <= 1'b0;
                    led_out <= 1'b0;
                    busy    <= 1'b1;
                end
            end else if (hcnt != HLAST) begin
                hcnt <= hcnt + HW'(1);
            end else begin
                hcnt <= '0;
                if (state == ST_GAP) begin
                    if (bcnt == GAP_LAST) begin
                        state      <= ST_IDLE;
                        bcnt       <= '0;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        bcnt <= bcnt + BW'(1);
                    end
                end else if (!half) begin
                    half    <= 1'b1;
                    led_out <= cur_bit;
                end else begin
                    half <= 1'b0;
                    case (state)
                        ST_PREAMBLE: begin
                            if (bcnt == PRE_LAST) begin
                                state   <= ST_DATA;
                                bcnt    <= '0;
                                led_out <= ~shreg[7];
                            end else begin
                                bcnt    <= bcnt + BW'(1);
                                led_out <= ~bcnt[0];
                            end
                        end
                        ST_DATA: begin
                            if (bcnt == DATA_LAST) begin
                                state   <= ST_PARITY;
                                bcnt    <= '0;
                                led_out <= ~par;
                            end else begin
                                bcnt    <= bcnt + BW'(1);
                                shreg   <= {shreg[6:0], 1'b0};
                                led_out <= ~shreg[6];
                            end
                        end
                        ST_PARITY: begin
                            state   <= ST_GAP;
                            bcnt    <= '0;
                            led_out <= IDLE_LEVEL;
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_vlc_manchester_tx.sv
// Directed bench for vlc_manchester_tx at default parameters (190-cycle frame).
module tb_vlc_manchester_tx;

    logic       aclk = 1'b0;
    logic       resetn;
    logic       tx_en;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       led_out;
    logic       busy;
    logic       frame_done;

    int vectors     = 0;
    int miscompares = 0;

    vlc_manchester_tx dut (
        .aclk       (aclk),
        .resetn     (resetn),
        .tx_en      (tx_en),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .led_out    (led_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic obs, input logic expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Expected line level at cycle i (0-based from first frame cycle)
    function automatic logic exp_led(input logic [7:0] d, input logic p, input int i);
        int  h;
        int  b;
        logic bv;
        h = i / 5;
        b = h / 2;
        if (b < 8)       bv = ((b % 2) == 0);
        else if (b < 16) bv = d[15 - b];
        else if (b == 16) bv = p;
        else return 1'b0;
        return (h % 2 == 1) ? bv : ~bv;
    endfunction

    // Checks cycles 1..n of a frame; optionally drops tx_en after cycle drop_at
    task automatic frame_cycles(input logic [7:0] d, input logic p, input int n, input int drop_at);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("led[%0d]", i), led_out, exp_led(d, p, i));
            chk($sformatf("busy[%0d]", i), busy, 1'b1);
            chk($sformatf("rdy[%0d]", i), s_ready, 1'b0);
            chk($sformatf("done[%0d]", i), frame_done, 1'b0);
            if (i == drop_at) tx_en = 1'b0;
            if (i < n - 1) step();
        end
    endtask

    // Full frame plus the frame_done cycle
    task automatic frame_full(input logic [7:0] d, input logic p, input int drop_at);
        frame_cycles(d, p, 190, drop_at);
        step();
        chk("end_done", frame_done, 1'b1);
        chk("end_busy", busy, 1'b0);
        chk("end_led", led_out, 1'b0);
        chk("end_rdy", s_ready, tx_en);
    endtask

    task automatic handshake(input logic [7:0] d, input logic keep);
        s_data  = d;
        s_valid = 1'b1;
        chk("hs_rdy", s_ready, 1'b1);
        step();
        if (!keep) s_valid = 1'b0;
    endtask

    initial begin
        resetn  = 1'b0;
        tx_en   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hFF;

        // 1: reset held with valid/enable asserted
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_led", led_out, 1'b0);
            chk("rst_rdy", s_ready, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_done", frame_done, 1'b0);
        end
        s_valid = 1'b0;
        resetn  = 1'b1;
        step();
        chk("idle_rdy", s_ready, 1'b1);
        chk("idle_led", led_out, 1'b0);

        // 2: 0xA5, parity 0
        handshake(8'hA5, 1'b0);
        frame_full(8'hA5, 1'b0, -1);
        step();
        chk("done_pulse", frame_done, 1'b0);

        // 3: 0x01, parity 1
        handshake(8'h01, 1'b0);
        frame_full(8'h01, 1'b1, -1);
        step();

        // 4: back-to-back 0x3C then 0xC3
        handshake(8'h3C, 1'b1);
        s_data = 8'hC3;
        frame_full(8'h3C, 1'b0, -1);
        step();
        s_valid = 1'b0;
        frame_full(8'hC3, 1'b0, -1);
        step();

        // 5: tx_en low blocks accept; drop mid-frame is ignored
        tx_en   = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h5A;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("dis_rdy", s_ready, 1'b0);
            chk("dis_led", led_out, 1'b0);
            chk("dis_busy", busy, 1'b0);
        end
        s_valid = 1'b0;
        tx_en   = 1'b1;
        #1;
        handshake(8'h07, 1'b0);
        frame_full(8'h07, 1'b1, 49);
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            step();
            chk("post_rdy", s_ready, 1'b0);
            chk("post_busy", busy, 1'b0);
        end
        s_valid = 1'b0;
        tx_en   = 1'b1;
        #1;
        chk("reen_rdy", s_ready, 1'b1);
        step();

        // 6: one-cycle reset at cycle 100 aborts the frame
        handshake(8'h96, 1'b0);
        frame_cycles(8'h96, 1'b0, 100, -1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_rdy", s_ready, 1'b0);
        step();
        resetn = 1'b1;
        chk("abort_led", led_out, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", frame_done, 1'b0);
        #1;
        chk("abort_idle", s_ready, 1'b1);
        handshake(8'hE1, 1'b0);
        frame_full(8'hE1, 1'b0, -1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
